muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit in the EX stage, beside the single-cycle ALU.

---
 rtl/muldiv_unit_pkg.sv | 67 ++++++
 rtl/muldiv_unit_if.sv | 28 ++
 rtl/muldiv_unit.sv | 180 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared RV32M multiply/divide types and helpers used by the EX stage, decoder and hazard unit.
// Helpers work on zero-extended 64-bit values with an explicit width, so any XLEN up to 64 can reuse them.
package muldiv_unit_pkg;

    localparam int MULDIV_XLEN  = 32;
    localparam int MULDIV_TAG_W = 5;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } muldiv_op_type;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_type;

    typedef struct packed {
        muldiv_op_type             op;
        logic [MULDIV_XLEN-1:0]    rs1;
        logic [MULDIV_XLEN-1:0]    rs2;
        logic [MULDIV_TAG_W-1:0]   rd_tag;
    } muldiv_req_type;

    function automatic logic [63:0] width_mask(input int unsigned w);
        if (w >= 32'd64) begin
            return {64{1'b1}};
        end else begin
            return (64'd1 << w) - 64'd1;
        end
    endfunction

    // Magnitude of a w-bit value when it is treated as signed, the value itself otherwise.
    function automatic logic [63:0] abs_if_signed(input logic [63:0] x, input int unsigned w,
                                                  input logic sgn);
        logic [63:0] m;
        logic        msb;
        m   = width_mask(w);
        msb = (x & (64'd1 << (w - 32'd1))) != 64'd0;
        if (sgn && msb) begin
            return (~x + 64'd1) & m;
        end else begin
            return x & m;
        end
    endfunction

    // Divide by zero, or signed most-negative / -1 overflow.
    function automatic logic is_div_special(input muldiv_op_type op, input logic [63:0] a,
                                            input logic [63:0] b, input int unsigned w);
        logic [63:0] m;
        logic [63:0] min_v;
        logic        sdiv;
        m     = width_mask(w);
        min_v = 64'd1 << (w - 32'd1);
        sdiv  = (op == DIV) || (op == REM);
        return op[2] && (((b & m) == 64'd0) ||
                         (sdiv && ((a & m) == min_v) && ((b & m) == m)));
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result handshake between the EX stage and the iterative multiply/divide unit.
interface muldiv_unit_if #(
    parameter int XLEN  = muldiv_unit_pkg::MULDIV_XLEN,
    parameter int TAG_W = muldiv_unit_pkg::MULDIV_TAG_W
);
    logic                          flush;
    logic                          in_valid;
    logic                          in_ready;
    muldiv_unit_pkg::muldiv_op_type op;
    logic [XLEN-1:0]               rs1;
    logic [XLEN-1:0]               rs2;
    logic [TAG_W-1:0]              rd_tag;
    logic                          out_valid;
    logic                          out_ready;
    logic [XLEN-1:0]               result;
    logic [TAG_W-1:0]              out_tag;
    logic                          busy;

    modport master (
        output flush, in_valid, op, rs1, rs2, rd_tag, out_ready,
        input  in_ready, out_valid, result, out_tag, busy
    );

    modport slave (
        input  flush, in_valid, op, rs1, rs2, rd_tag, out_ready,
        output in_ready, out_valid, result, out_tag, busy
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 shift-add / restoring-subtract step per cycle.
// Optional MULDIV_EARLY_OUT_EN retires divide-by-zero, DIV overflow and zero-operand multiplies in one step.
module muldiv_unit #(
    parameter int XLEN  = muldiv_unit_pkg::MULDIV_XLEN,
    parameter int TAG_W = muldiv_unit_pkg::MULDIV_TAG_W
) (
    input  logic            clk,
    input  logic            reset_n,
    muldiv_unit_if.slave    bus
);
    import muldiv_unit_pkg::*;

    localparam int             CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_CNT  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    muldiv_state_type   state_r, state_s;
    muldiv_op_type      op_r;
    logic [XLEN-1:0]    acc_r, mq_r, opb_r, result_r;
    logic [TAG_W-1:0]   tag_r;
    logic [CNT_W-1:0]   count_r;
    logic               neg_r, special_r;
    logic               out_valid_r, in_ready_r, busy_r;

    logic               accept_s, last_s, s1_s, s2_s, neg_in_s, early_hit_s;
    logic [XLEN-1:0]    abs1_s, abs2_s, special_s, acc_n_s, mq_n_s, final_s;
    logic [XLEN:0]      mul_sum_s, div_shift_s, div_diff_s;
    logic [2*XLEN-1:0]  prod_s;

    assign accept_s = bus.in_valid && (state_r == IDLE) && !bus.flush;
    assign last_s   = (count_r == LAST_CNT);

    // Operand magnitudes and the sign to re-apply once the unsigned core finishes.
    always_comb begin
        s1_s   = bus.op inside {MUL, MULH, MULHSU, DIV, REM};
        s2_s   = bus.op inside {MUL, MULH, DIV, REM};
        abs1_s = XLEN'(abs_if_signed(64'(bus.rs1), XLEN, s1_s));
        abs2_s = XLEN'(abs_if_signed(64'(bus.rs2), XLEN, s2_s));
        case (bus.op)
            MUL, MULH: neg_in_s = bus.rs1[XLEN-1] ^ bus.rs2[XLEN-1];
            MULHSU:    neg_in_s = bus.rs1[XLEN-1];
            // A zero divisor must leave the all-ones quotient unnegated.
            DIV:       neg_in_s = (bus.rs1[XLEN-1] ^ bus.rs2[XLEN-1]) && (bus.rs2 != {XLEN{1'b0}});
            REM:       neg_in_s = bus.rs1[XLEN-1];
            default:   neg_in_s = 1'b0;
        endcase
    end

`ifdef MULDIV_EARLY_OUT_EN
    // Special-case detection and its architectural result at acceptance.
    always_comb begin
        early_hit_s = is_div_special(bus.op, 64'(bus.rs1), 64'(bus.rs2), XLEN) ||
                      (!bus.op[2] && ((bus.rs1 == {XLEN{1'b0}}) || (bus.rs2 == {XLEN{1'b0}})));
        case (bus.op)
            DIV, DIVU: special_s = (bus.rs2 == {XLEN{1'b0}}) ? {XLEN{1'b1}} : bus.rs1;
            REM, REMU: special_s = (bus.rs2 == {XLEN{1'b0}}) ? bus.rs1 : {XLEN{1'b0}};
            default:   special_s = {XLEN{1'b0}};
        endcase
    end
`else
    // Without early-out every op runs the full iteration; the core already yields the special values.
    always_comb begin
        early_hit_s = 1'b0;
        special_s   = {XLEN{1'b0}};
    end
`endif

    // One datapath step plus the sign-corrected result used on the final step.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r} + (mq_r[0] ? {1'b0, opb_r} : {(XLEN+1){1'b0}});
        div_shift_s = {acc_r, mq_r[XLEN-1]};
        div_diff_s  = div_shift_s - {1'b0, opb_r};
        if (!op_r[2]) begin
            acc_n_s = mul_sum_s[XLEN:1];
            mq_n_s  = {mul_sum_s[0], mq_r[XLEN-1:1]};
        end else begin
            acc_n_s = div_diff_s[XLEN] ? div_shift_s[XLEN-1:0] : div_diff_s[XLEN-1:0];
            mq_n_s  = {mq_r[XLEN-2:0], ~div_diff_s[XLEN]};
        end
        prod_s = neg_r ? -{acc_n_s, mq_n_s} : {acc_n_s, mq_n_s};
        case (op_r)
            MUL:                 final_s = prod_s[XLEN-1:0];
            MULH, MULHSU, MULHU: final_s = prod_s[2*XLEN-1:XLEN];
            DIV, DIVU:           final_s = neg_r ? -mq_n_s : mq_n_s;
            REM, REMU:           final_s = neg_r ? -acc_n_s : acc_n_s;
            default:             final_s = {XLEN{1'b0}};
        endcase
    end

    // Next-state logic; flush overrides everything.
    always_comb begin
        state_s = state_r;
        if (bus.flush) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    state_s = accept_s ? CALC : IDLE;
                CALC:    state_s = last_s ? DONE : CALC;
                DONE:    state_s = bus.out_ready ? IDLE : DONE;
                default: state_s = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand latch, iteration and result capture; early-out hits retire on the first CALC edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_r      <= MUL;
            tag_r     <= {TAG_W{1'b0}};
            neg_r     <= 1'b0;
            special_r <= 1'b0;
            acc_r     <= {XLEN{1'b0}};
            mq_r      <= {XLEN{1'b0}};
            opb_r     <= {XLEN{1'b0}};
            result_r  <= {XLEN{1'b0}};
            count_r   <= ZERO_CNT;
        end else if (bus.flush) begin
            count_r   <= ZERO_CNT;
            special_r <= 1'b0;
        end else if (accept_s) begin
            op_r      <= bus.op;
            tag_r     <= bus.rd_tag;
            neg_r     <= neg_in_s;
            special_r <= early_hit_s;
            acc_r     <= {XLEN{1'b0}};
            count_r   <= early_hit_s ? LAST_CNT : ZERO_CNT;
            if (bus.op[2]) begin
                mq_r  <= abs1_s;
                opb_r <= abs2_s;
            end else begin
                mq_r  <= abs2_s;
                opb_r <= abs1_s;
            end
            if (early_hit_s) begin
                result_r <= special_s;
            end
        end else if (state_r == CALC) begin
            acc_r <= acc_n_s;
            mq_r  <= mq_n_s;
            if (last_s) begin
                count_r <= ZERO_CNT;
                if (!special_r) begin
                    result_r <= final_s;
                end
            end else begin
                count_r <= count_r + ONE_CNT;
            end
        end
    end

    // Handshake outputs registered from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            out_valid_r <= (state_s == DONE);
            in_ready_r  <= (state_s == IDLE);
            busy_r      <= (state_s != IDLE);
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.result    = result_r;
    assign bus.out_tag   = tag_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, randomized ops against an arithmetic model,
// and hand-written backpressure / flush / reset sequences.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();
    muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    int total = 0;
    int bad   = 0;

    typedef struct {
        muldiv_op_type op;
        logic [31:0]   a;
        logic [31:0]   b;
        logic [31:0]   exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: RV32M semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_result(input muldiv_op_type op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        int              si, ti;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        si = $signed(a);
        ti = $signed(b);
        p  = 64'd0;
        case (op)
            MUL:    begin p = sa * sb;           return p[31:0];  end
            MULH:   begin p = sa * sb;           return p[63:32]; end
            MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
            MULHU:  begin p = ua * ub;           return p[63:32]; end
            DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return si / ti;
            end
            REM: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return si % ti;
            end
            DIVU:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            REMU:    return (b == 32'd0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int exp_latency(input muldiv_op_type op, input logic [31:0] a,
                                       input logic [31:0] b);
        bit special;
        special = 1'b0;
        if (op inside {MUL, MULH, MULHSU, MULHU}) special = (a == 32'd0) || (b == 32'd0);
        else special = (b == 32'd0) ||
                       ((op inside {DIV, REM}) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef MULDIV_EARLY_OUT_EN
        return special ? 1 : 32;
`else
        return special ? 32 : 32;
`endif
    endfunction

    // Issue one request from a negedge; return the result seen when out_valid rises and the cycles taken.
    task automatic issue(input muldiv_op_type op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, output logic [31:0] res, output int lat,
                         output logic [4:0] otag);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.rs1      = a;
        bus.rs2      = b;
        bus.rd_tag   = tag;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        res  = bus.result;
        otag = bus.out_tag;
    endtask

    task automatic run_checked(input string name, input muldiv_op_type op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp, input logic [4:0] tag);
        logic [31:0] res;
        logic [4:0]  otag;
        int          lat;
        issue(op, a, b, tag, res, lat, otag);
        check({name, " result"}, res, exp);
        check({name, " latency"}, 32'(lat), 32'(exp_latency(op, a, b)));
        check({name, " tag"}, 32'(otag), 32'(tag));
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        vec_t        vecs[15];
        logic [31:0] a, b, res;
        logic [4:0]  otag;
        int          lat;
        bit          saw_valid;
        muldiv_op_type op;

        vecs[0]  = '{MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
        vecs[2]  = '{MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[3]  = '{MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4]  = '{DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
        vecs[5]  = '{REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
        vecs[6]  = '{DIVU,   32'hFFFF_FFF9,  32'd2,         32'h7FFF_FFFC};
        vecs[7]  = '{REMU,   32'hFFFF_FFF9,  32'd2,         32'h0000_0001};
        vecs[8]  = '{DIV,    32'd5,          32'd0,         32'hFFFF_FFFF};
        vecs[9]  = '{REM,    32'd5,          32'd0,         32'h0000_0005};
        vecs[10] = '{DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        vecs[11] = '{REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000};
        vecs[12] = '{MUL,    32'h1234_5678,  32'd0,         32'h0000_0000};
        vecs[13] = '{DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF};
        vecs[14] = '{REMU,   32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9};

        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.op = MUL; bus.rs1 = 32'd0; bus.rs2 = 32'd0;
        bus.rd_tag = 5'd0; bus.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset result", bus.result, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("post-reset in_ready", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < 15; i++) begin
            run_checked($sformatf("vec%0d %s", i, vecs[i].op.name()), vecs[i].op, vecs[i].a,
                        vecs[i].b, vecs[i].exp, 5'(i + 3));
        end

        for (int i = 0; i < 60; i++) begin
            op = muldiv_op_type'(3'($urandom_range(0, 7)));
            a  = pick_operand();
            b  = pick_operand();
            run_checked($sformatf("rnd%0d %s %h %h", i, op.name(), a, b), op, a, b,
                        ref_result(op, a, b), 5'($urandom));
        end

        // Backpressure: result held while out_ready is low.
        @(negedge clk);
        bus.out_ready = 1'b0;
        issue(MUL, 32'd7, 32'hFFFF_FFFD, 5'd9, res, lat, otag);
        check("hold first result", res, 32'hFFFF_FFEB);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold out_valid", 32'(bus.out_valid), 32'd1);
            check("hold result", bus.result, 32'hFFFF_FFEB);
            check("hold out_tag", 32'(bus.out_tag), 32'd9);
            check("hold in_ready", 32'(bus.in_ready), 32'd0);
            check("hold busy", 32'(bus.busy), 32'd1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("release out_valid", 32'(bus.out_valid), 32'd0);
        check("release in_ready", 32'(bus.in_ready), 32'd1);

        // A request presented together with flush is ignored.
        bus.in_valid = 1'b1; bus.flush = 1'b1; bus.op = DIVU; bus.rs1 = 32'd100; bus.rs2 = 32'd3;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0; bus.flush = 1'b0;
        check("flush-req busy", 32'(bus.busy), 32'd0);
        check("flush-req in_ready", 32'(bus.in_ready), 32'd1);

        // Flush at CALC count 10: work discarded, unit ready next cycle.
        bus.in_valid = 1'b1; bus.op = DIVU; bus.rs1 = 32'd1000; bus.rs2 = 32'd7; bus.rd_tag = 5'd4;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            saw_valid |= bus.out_valid;
        end
        bus.flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush out_valid", 32'(bus.out_valid), 32'd0);
        check("flush in_ready", 32'(bus.in_ready), 32'd1);
        check("flush busy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            saw_valid |= bus.out_valid;
        end
        check("flush no stray valid", 32'(saw_valid), 32'd0);
        run_checked("after flush DIVU", DIVU, 32'd1000, 32'd7, 32'd142, 5'd6);

        // Async reset mid-CALC.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = MUL; bus.rs1 = 32'd3; bus.rs2 = 32'd5; bus.rd_tag = 5'd21;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midreset in_ready", 32'(bus.in_ready), 32'd1);
        check("midreset busy", 32'(bus.busy), 32'd0);
        check("midreset out_valid", 32'(bus.out_valid), 32'd0);
        check("midreset result", bus.result, 32'd0);
        check("midreset out_tag", 32'(bus.out_tag), 32'd0);
        #2;
        reset_n = 1'b1;
        @(negedge clk);
        run_checked("after reset MULHU", MULHU, 32'hDEAD_BEEF, 32'h1234_5678,
                    ref_result(MULHU, 32'hDEAD_BEEF, 32'h1234_5678), 5'd17);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
